audio_i2s_clkgen: RTL and testbench

- I2S bit-clock/frame-clock master for the WM8731 codec path. Derives BCLK and LRCK from the audio PLL clock. Drives the codec pins and the audio core's BCLK/ADCLRCK/DACLRCK inputs, so it sits directly upstream of the audio core.
- Also deserialises ADCDAT into left/right sample pairs. Keeps a per-channel decaying 8-bit peak level for LED metering.

---
 rtl/audio_pkg.sv | 25 ++
 rtl/audio_peak_meter.sv | 38 +++
 rtl/audio_i2s_clkgen.sv | 149 ++++++++++++++
 tb/tb_audio_i2s_clkgen.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types and helpers for the I2S clock generator and meters.
package audio_pkg;

  localparam int unsigned AUD_DATA_WIDTH = 24;
  localparam int unsigned AUD_SLOT_BITS  = 32;

  typedef logic signed [AUD_DATA_WIDTH-1:0] aud_sample_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } run_state_t;

  // Saturating magnitude of a sign-extended sample, top 8 bits below the sign.
  function automatic logic [7:0] sat_abs_top8(input logic signed [63:0] sample,
                                              input int unsigned width);
    logic [63:0] mag;
    logic [63:0] max_pos;
    max_pos = (64'd1 << (width - 1)) - 64'd1;
    mag     = sample[63] ? 64'(-sample) : 64'(sample);
    if (mag > max_pos) mag = max_pos;
    return 8'(mag >> (width - 9));
  endfunction

endpackage

// File: rtl/audio_peak_meter.sv
// Per-channel decaying peak level; updates only on a new-sample strobe.
module audio_peak_meter
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  load,
  input  logic                  decay_tick,
  output logic [7:0]            peak
);

  logic [7:0] mag8;
  logic [7:0] peak_d;

  always_comb begin
    mag8   = sat_abs_top8(64'($signed(sample)), DATA_WIDTH);
    peak_d = peak;
    if (load) begin
      if (mag8 > peak) begin
        peak_d = mag8;
      end else if (decay_tick && (peak != '0)) begin
        peak_d = peak - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak <= '0;
    end else begin
      peak <= peak_d;
    end
  end

endmodule

// File: rtl/audio_i2s_clkgen.sv
// I2S BCLK/LRCK master for the codec path, with ADC deserialiser and peak meters.
module audio_i2s_clkgen
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned SLOT_BITS    = AUD_SLOT_BITS,
  parameter int unsigned DATA_WIDTH   = AUD_DATA_WIDTH,
  parameter int unsigned DECAY_FRAMES = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  aud_bclk,
  output logic                  aud_lrck,
  input  logic                  aud_adcdat,
  output logic [DATA_WIDTH-1:0] adc_left,
  output logic [DATA_WIDTH-1:0] adc_right,
  output logic                  adc_valid,
  output logic                  frame_start,
  output logic [7:0]            peak_left,
  output logic [7:0]            peak_right
);

  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);
  localparam int unsigned DEC_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(HALF - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] BIT_DW   = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_FRAMES - 1);
  localparam logic [DEC_W-1:0] DEC_ONE  = DEC_W'(1);

  run_state_t            state_q, state_d;
  logic [DIV_W-1:0]      div_cnt, div_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt, slot_pos;
  logic [DATA_WIDTH-1:0] shift_l, shift_r;
  logic [DEC_W-1:0]      dec_cnt;
  logic                  tick, rise_evt, fall_evt, in_right, cap_bit;
  logic                  cap_done, in_q, decay_tick;

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      state_d = ST_RUN;
    end
  end

  // The first enabled cycle is a start cycle: counters stay at 0 so the frame
  // begins on a clean BCLK-low phase and frame_start lines up with bit 0.
  always_comb begin
    tick     = enable && (state_q == ST_RUN);
    rise_evt = tick && (div_cnt == DIV_RISE);
    fall_evt = tick && (div_cnt == DIV_LAST);
    in_right = (bit_cnt >= BIT_SLOT);
    slot_pos = in_right ? (bit_cnt - BIT_SLOT) : bit_cnt;
    cap_bit  = rise_evt && (slot_pos != '0) && (slot_pos <= BIT_DW);

    div_nxt = '0;
    if (tick) div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;

    bit_nxt = enable ? bit_cnt : '0;
    if (fall_evt) bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_ONE;

    decay_tick = adc_valid && (dec_cnt == DEC_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      aud_bclk    <= 1'b0;
      aud_lrck    <= 1'b0;
      in_q        <= 1'b0;
      frame_start <= 1'b0;
      shift_l     <= '0;
      shift_r     <= '0;
      cap_done    <= 1'b0;
      adc_valid   <= 1'b0;
      adc_left    <= '0;
      adc_right   <= '0;
      dec_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt     <= div_nxt;
      bit_cnt     <= bit_nxt;
      aud_bclk    <= (div_nxt >= DIV_HALF);
      aud_lrck    <= (bit_nxt >= BIT_SLOT);
      in_q        <= aud_adcdat;
      frame_start <= enable && ((state_q == ST_IDLE) || (fall_evt && (bit_cnt == BIT_LAST)));

      if (!enable) begin
        shift_l <= '0;
        shift_r <= '0;
      end else if (cap_bit) begin
        if (in_right) begin
          shift_r <= {shift_r[DATA_WIDTH-2:0], in_q};
        end else begin
          shift_l <= {shift_l[DATA_WIDTH-2:0], in_q};
        end
      end

      cap_done  <= cap_bit && in_right && (slot_pos == BIT_DW);
      adc_valid <= enable && cap_done;
      if (enable && cap_done) begin
        adc_left  <= shift_l;
        adc_right <= shift_r;
      end

      if (!enable) begin
        dec_cnt <= '0;
      end else if (adc_valid) begin
        dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + DEC_ONE;
      end
    end
  end

  audio_peak_meter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_peak_left (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample    (adc_left),
    .load      (adc_valid),
    .decay_tick(decay_tick),
    .peak      (peak_left)
  );

  audio_peak_meter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_peak_right (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample    (adc_right),
    .load      (adc_valid),
    .decay_tick(decay_tick),
    .peak      (peak_right)
  );

endmodule

// File: tb/tb_audio_i2s_clkgen.sv
// Bench for audio_i2s_clkgen: I2S codec driver, frame-arithmetic model, per-cycle compare.
module tb_audio_i2s_clkgen;

  localparam int CLK_DIV = 4;
  localparam int SLOT    = 32;
  localparam int DW      = 24;
  localparam int DECAY   = 4;
  localparam int FRAME   = CLK_DIV * 2 * SLOT;
  // right-slot LSB launched at bit SLOT+DW, valid CLK_DIV/2+1 cycles later
  localparam int VALID_K = (SLOT + DW) * CLK_DIV + CLK_DIV / 2 + 1;

  logic          clk, reset_n, enable, aud_adcdat;
  logic          aud_bclk, aud_lrck, adc_valid, frame_start;
  logic [DW-1:0] adc_left, adc_right;
  logic [7:0]    peak_left, peak_right;

  audio_i2s_clkgen #(
    .CLK_DIV     (CLK_DIV),
    .SLOT_BITS   (SLOT),
    .DATA_WIDTH  (DW),
    .DECAY_FRAMES(DECAY)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .aud_bclk   (aud_bclk),
    .aud_lrck   (aud_lrck),
    .aud_adcdat (aud_adcdat),
    .adc_left   (adc_left),
    .adc_right  (adc_right),
    .adc_valid  (adc_valid),
    .frame_start(frame_start),
    .peak_left  (peak_left),
    .peak_right (peak_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-frame codec words; frames past the table repeat the last entry.
  logic [DW-1:0] wl[16];
  logic [DW-1:0] wr[16];
  bit            wp[16];
  int            nwords = 1;

  task automatic set_word(input int i, input logic [DW-1:0] l, input logic [DW-1:0] r, input bit pad);
    wl[i] = l;
    wr[i] = r;
    wp[i] = pad;
  endtask

  function automatic int frame_idx(input int k);
    int f;
    f = k / FRAME;
    if (f >= nwords) f = nwords - 1;
    return f;
  endfunction

  function automatic logic codec_bit(input int k);
    int            b, p, f;
    logic [DW-1:0] w;
    if (k < 0) return 1'b0;
    f = frame_idx(k);
    b = (k / CLK_DIV) % (2 * SLOT);
    p = b % SLOT;
    w = (b >= SLOT) ? wr[f] : wl[f];
    if (p >= 1 && p <= DW) return w[DW - p];
    return logic'(wp[f]);
  endfunction

  function automatic int mag8(input logic [DW-1:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > (1 << (DW - 1)) - 1) v = (1 << (DW - 1)) - 1;
    return v / (1 << (DW - 9));
  endfunction

  function automatic int next_peak(input int pk, input int m, input bit decay);
    if (m > pk) return m;
    if (decay && pk > 0) return pk - 1;
    return pk;
  endfunction

  // Model: mk = clk cycles since the running frame sequence began (-1 = stopped).
  int            mk = -1;
  int            vcount = 0;
  int            pk_l = 0, pk_r = 0;
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_left = '0, m_right = '0;

  initial begin
    bit dec;
    int f;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mk = -1; vcount = 0; pk_l = 0; pk_r = 0;
        m_valid = 1'b0; m_left = '0; m_right = '0;
      end else begin
        if (m_valid) begin
          dec  = ((vcount % DECAY) == DECAY - 1);
          pk_l = next_peak(pk_l, mag8(m_left), dec);
          pk_r = next_peak(pk_r, mag8(m_right), dec);
        end
        if (!enable) vcount = 0;
        else if (m_valid) vcount++;
        mk      = enable ? mk + 1 : -1;
        m_valid = (mk >= 0) && ((mk % FRAME) == VALID_K);
        if (m_valid) begin
          f       = frame_idx(mk);
          m_left  = wl[f];
          m_right = wr[f];
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      aud_adcdat = codec_bit(mk);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("bclk",  32'(aud_bclk),    32'((mk >= 0) && ((mk % CLK_DIV) >= CLK_DIV / 2)));
        check("lrck",  32'(aud_lrck),    32'((mk >= 0) && (((mk / CLK_DIV) % (2 * SLOT)) >= SLOT)));
        check("fstart", 32'(frame_start), 32'((mk >= 0) && ((mk % FRAME) == 0)));
        check("valid", 32'(adc_valid),   32'(m_valid));
        check("left",  32'(adc_left),    32'(m_left));
        check("right", 32'(adc_right),   32'(m_right));
        check("peakl", 32'(peak_left),   32'(pk_l));
        check("peakr", 32'(peak_right),  32'(pk_r));
      end
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (adc_valid !== 1'b1 && n < 2 * FRAME);
    if (adc_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: no adc_valid within %0d cycles", n);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bclk"},  32'(aud_bclk),    32'h0);
    check({tag, "_lrck"},  32'(aud_lrck),    32'h0);
    check({tag, "_valid"}, 32'(adc_valid),   32'h0);
    check({tag, "_fs"},    32'(frame_start), 32'h0);
    check({tag, "_left"},  32'(adc_left),    32'h0);
    check({tag, "_right"}, 32'(adc_right),   32'h0);
    check({tag, "_pkl"},   32'(peak_left),   32'h0);
    check({tag, "_pkr"},   32'(peak_right),  32'h0);
  endtask

  initial begin
    int n, nv, target;
    reset_n    = 1'b0;
    enable     = 1'b1;
    aud_adcdat = 1'b0;

    for (int i = 0; i < 16; i++) set_word(i, '0, '0, 1'b0);
    set_word(0, 24'h123456, 24'hEDCBA9, 1'b0);
    set_word(1, 24'h000001, 24'h000000, 1'b1);
    set_word(2, 24'h000000, 24'h800000, 1'b0);
    set_word(8, 24'h0ABCDE, 24'h7FFFFF, 1'b0);
    set_word(9, 24'h555555, 24'h2AAAAA, 1'b0);
    nwords = 10;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #2 reset_n = 1'b1;
    cmp_on = 1'b1;

    wait_valid(n);
    check("cap_left",  32'(adc_left),  32'h123456);
    check("cap_right", 32'(adc_right), 32'hEDCBA9);
    @(negedge clk);
    check("cap_single",  32'(adc_valid),  32'h0);
    check("cap_peak_l",  32'(peak_left),  32'h24);
    check("cap_peak_r",  32'(peak_right), 32'h24);

    wait_valid(n);
    check("pad_left",  32'(adc_left),  32'h000001);
    check("pad_right", 32'(adc_right), 32'h000000);

    wait_valid(n);
    @(negedge clk);
    check("sat_peak_r", 32'(peak_right), 32'hFF);

    wait_valid(n);
    @(negedge clk);
    check("decay_peak_r", 32'(peak_right), 32'hFE);
    check("decay_peak_l", 32'(peak_left),  32'h23);

    repeat (5) wait_valid(n);
    check("pre_abort_left", 32'(adc_left), 32'h0ABCDE);

    // drop enable at bit_cnt=40 of frame 9 (right slot)
    target = 9 * FRAME + 40 * CLK_DIV + 2;
    n = 0;
    while (mk != target && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", 32'(mk), 32'(target));
    enable = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_bclk",  32'(aud_bclk),  32'h0);
    check("abort_lrck",  32'(aud_lrck),  32'h0);
    check("abort_left",  32'(adc_left),  32'h0ABCDE);
    check("abort_right", 32'(adc_right), 32'h7FFFFF);
    nv = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (adc_valid === 1'b1) nv++;
    end
    check("abort_novalid", 32'(nv), 32'h0);

    for (int i = 0; i < 16; i++) set_word(i, '0, '0, 1'b0);
    set_word(0, 24'h555555, 24'h2AAAAA, 1'b0);
    nwords = 2;
    enable = 1'b1;
    wait_valid(n);
    check("reen_left",  32'(adc_left),  32'h555555);
    check("reen_right", 32'(adc_right), 32'h2AAAAA);

    repeat (100) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async");

    for (int i = 0; i < 16; i++) set_word(i, '0, '0, 1'b0);
    set_word(0, 24'h030000, 24'hFD0000, 1'b0);
    nwords = 2;
    @(negedge clk);
    #2 reset_n = 1'b1;
    wait_valid(n);
    check("restart_latency", 32'(n), 32'd228);
    check("restart_left",    32'(adc_left), 32'h030000);
    @(negedge clk);
    check("restart_peak_l", 32'(peak_left),  32'h06);
    check("restart_peak_r", 32'(peak_right), 32'h06);

    repeat (26) wait_valid(n);
    @(negedge clk);
    check("floor_peak_l", 32'(peak_left),  32'h00);
    check("floor_peak_r", 32'(peak_right), 32'h00);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
